// File: rtl/imem_loader_pkg.sv
// Shared state encoding and framing constants for the instruction-memory boot loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CNT_LO,
      CNT_HI,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int CNT_BYTES      = 2;

endpackage

// File: rtl/imem_loader_word_pack.sv
// Packs a byte stream into little-endian 32-bit words; word_valid pulses the cycle after the 4th byte.
module imem_loader_word_pack
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam int               IDX_W    = $clog2(BYTES_PER_WORD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   logic [IDX_W-1:0] byte_idx;

   // NOTE: non-blocking assignments so every register here samples the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word       <= '0;
         byte_idx   <= '0;
         word_valid <= 1'b0;
      end else if (clear) begin
         word       <= '0;
         byte_idx   <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= byte_valid && (byte_idx == LAST_IDX);
         if (byte_valid) begin
            // Newest byte enters at the top, so the first byte ends up in [7:0].
            word     <= {byte_data, word[31:8]};
            byte_idx <= byte_idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader for the instruction memory; holds the core in reset until the image is in.
// Optional trailing checksum byte: define IMEM_LOADER_CSUM_EN.
module imem_boot_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int MAX_WORDS = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t            state, state_nxt;
   logic              accept, start_ok, last_write, pack_valid, word_valid;
   logic [7:0]        cnt_lo;
   logic [15:0]       word_cnt, n_rx;
   logic [ADDR_W-1:0] addr;
   logic [16:0]       next_idx;
   logic [31:0]       word;

   assign accept     = rx_valid && rx_ready;
   assign start_ok   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
   assign n_rx       = {rx_data, cnt_lo};
   assign next_idx   = 17'(addr) + 17'd1;
   assign last_write = word_valid && (next_idx == {1'b0, word_cnt});
   // A byte arriving during the final write belongs to the checksum, never to the packer.
   assign pack_valid = accept && (state == DATA) && !last_write;

`ifdef IMEM_LOADER_CSUM_EN
   localparam state_t FINISH_ST = CSUM;
   logic [7:0] csum;
   logic       csum_ok;

   assign csum_ok = (rx_data == csum);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum <= '0;
      end else if (start_ok) begin
         csum <= '0;
      end else if (accept && ((state == CNT_LO) || (state == CNT_HI) || (state == DATA))
                   && !last_write) begin
         csum <= csum + rx_data;
      end
   end
`else
   localparam state_t FINISH_ST = DONE;
`endif

   imem_loader_word_pack u_pack (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (start_ok),
      .byte_valid (pack_valid),
      .byte_data  (rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: state_nxt gets a default before the case so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR: if (start) state_nxt = CNT_LO;
         CNT_LO:          if (accept) state_nxt = CNT_HI;
         CNT_HI: begin
            if (accept) begin
               if (n_rx == '0)                          state_nxt = FINISH_ST;
               else if (32'(n_rx) > 32'(MAX_WORDS))     state_nxt = ERR;
               else                                     state_nxt = DATA;
            end
         end
         DATA: begin
            if (last_write) begin
`ifdef IMEM_LOADER_CSUM_EN
               if (accept) state_nxt = csum_ok ? DONE : ERR;
               else        state_nxt = CSUM;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CSUM_EN
         CSUM: if (accept) state_nxt = csum_ok ? DONE : ERR;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_ready   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      core_rst_n = 1'b0;
      case (state)
         CNT_LO, CNT_HI, DATA, CSUM: begin
            rx_ready = 1'b1;
            busy     = 1'b1;
         end
         DONE: begin
            done       = 1'b1;
            core_rst_n = 1'b1;
         end
         ERR:     err = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_lo   <= '0;
         word_cnt <= '0;
         addr     <= '0;
      end else if (start_ok) begin
         word_cnt <= '0;
         addr     <= '0;
      end else begin
         if (accept && (state == CNT_LO)) cnt_lo   <= rx_data;
         if (accept && (state == CNT_HI)) word_cnt <= n_rx;
         if (word_valid && !last_write)   addr     <= addr + ADDR_W'(1);
      end
   end

   assign imem_we    = word_valid;
   assign imem_addr  = addr;
   assign imem_wdata = word;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed and randomized images against a stream-level model.
module tb_imem_boot_loader;

   localparam int ADDR_W    = 12;
   localparam int MAX_WORDS = 4096;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      int unsigned addr;
      logic [31:0] data;
      int unsigned cyc;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        rx_data = '0;
   logic              rx_valid = 1'b0;
   logic              rx_ready, imem_we, core_rst_n, busy, done, err;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   wr_t         wr_log[$];
   int unsigned acc_log[$];
   wr_t         mon_w;
   logic [31:0] tb_mem [MAX_WORDS];

   imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_rst_n (core_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observes the memory port and accepted bytes mid-cycle; cyc names the current cycle.
   always @(negedge clk) begin
      if (rst_n && imem_we) begin
         mon_w.addr = 32'(imem_addr);
         mon_w.data = imem_wdata;
         mon_w.cyc  = cyc;
         wr_log.push_back(mon_w);
         tb_mem[imem_addr] <= imem_wdata;
      end
      if (rst_n && rx_valid && rx_ready) acc_log.push_back(cyc);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic byte_q_t make_image(input int n);
      byte_q_t    q;
`ifdef IMEM_LOADER_CSUM_EN
      logic [7:0] sum;
`endif
      q.push_back(8'(n));
      q.push_back(8'(n >> 8));
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
`ifdef IMEM_LOADER_CSUM_EN
      sum = '0;
      foreach (q[k]) sum = sum + q[k];
      q.push_back(sum);
`endif
      return q;
   endfunction

   task automatic send_stream(input byte_q_t s, input int vpct, input int start_at);
      int guard;
      for (int i = 0; i < s.size(); i++) begin
         if (i == start_at) begin
            rx_valid = 1'b0;
            start    = 1'b1;
            @(negedge clk);
            start    = 1'b0;
         end
         while ($urandom_range(99) >= vpct) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
         end
         rx_valid = 1'b1;
         rx_data  = s[i];
         guard    = 0;
         while (!rx_ready && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         if (!rx_ready) begin
            checks++;
            errors++;
            $error("FAIL rx_ready_timeout: byte %0d never accepted", i);
            rx_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      rx_valid = 1'b0;
   endtask

   task automatic run_load(input string tag, input byte_q_t s, input int vpct, input int start_at);
      int          n, exp_words, idx;
      bit          exp_err;
      logic [7:0]  sum;
      logic [31:0] w;
      wr_log.delete();
      acc_log.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_on_start"}, busy, 1);
      check({tag, "_core_rst_on_start"}, core_rst_n, 0);
      send_stream(s, vpct, start_at);
      repeat (3) @(negedge clk);

      n         = int'({s[1], s[0]});
      exp_err   = (n > MAX_WORDS);
      exp_words = exp_err ? 0 : n;
      sum       = '0;
`ifdef IMEM_LOADER_CSUM_EN
      if (!exp_err) begin
         for (int k = 0; k < 2 + 4 * n; k++) sum = sum + s[k];
         exp_err = (sum != s[2 + 4 * n]);
      end
`endif
      check({tag, "_write_count"}, wr_log.size(), exp_words);
      for (int i = 0; i < exp_words && i < wr_log.size(); i++) begin
         w = {s[2 + 4*i + 3], s[2 + 4*i + 2], s[2 + 4*i + 1], s[2 + 4*i]};
         check($sformatf("%s_addr%0d", tag, i), wr_log[i].addr, i);
         check($sformatf("%s_data%0d", tag, i), wr_log[i].data, w);
         check($sformatf("%s_mem%0d", tag, i), tb_mem[i], w);
         idx = 2 + 4*i + 3;
         if (idx < acc_log.size())
            check($sformatf("%s_wr_cycle%0d", tag, i), wr_log[i].cyc, acc_log[idx] + 1);
      end
      check({tag, "_done"}, done, !exp_err);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_core_rst_n"}, core_rst_n, !exp_err);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_rx_ready"}, rx_ready, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rx_ready"}, rx_ready, 0);
      check({tag, "_imem_we"}, imem_we, 0);
      check({tag, "_imem_addr"}, imem_addr, 0);
      check({tag, "_imem_wdata"}, imem_wdata, 0);
      check({tag, "_core_rst_n"}, core_rst_n, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog expired");
   end

   initial begin
      byte_q_t s, part;
      logic [31:0] w0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      s = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
      s.push_back(8'hB8);
`endif
      run_load("two_words", s, 100, -1);
      check("two_words_lit0", tb_mem[0], 32'h0000_0013);
      check("two_words_lit1", tb_mem[1], 32'h0010_0093);

      s = {8'h00, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
      s.push_back(8'h00);
`endif
      run_load("empty", s, 100, -1);

      s = {8'h01, 8'h10};
      run_load("too_big", s, 100, -1);
      run_load("after_err", make_image(1), 100, -1);

      run_load("stall3", make_image(3), 50, -1);

      // Reset partway through the second word; the first word must already be in memory.
      s = make_image(3);
      part.delete();
      for (int i = 0; i < 7; i++) part.push_back(s[i]);
      wr_log.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send_stream(part, 100, -1);
      check("midrst_busy", busy, 1);
      check("midrst_writes", wr_log.size(), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      w0 = {s[5], s[4], s[3], s[2]};
      check("midrst_word0_kept", tb_mem[0], w0);
      run_load("after_rst", make_image(2), 100, -1);

`ifdef IMEM_LOADER_CSUM_EN
      s = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
      run_load("csum_good", s, 100, -1);
      check("csum_good_done", done, 1);
      s = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h15};
      run_load("csum_bad", s, 100, -1);
      check("csum_bad_err", err, 1);
      check("csum_bad_core_rst", core_rst_n, 0);
`endif

      for (int r = 0; r < 4; r++) begin
         s = make_image(int'($urandom_range(1, 8)));
         run_load($sformatf("rand%0d", r), s, int'($urandom_range(30, 100)),
                  int'($urandom_range(1, s.size() - 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
